// File: rtl/pinball_disp_pkg.sv
// Shared constants and types for the pinball score display path.
// Holds the digit codes, the encoder FSM states and a helper that
// gives the largest value a given number of decimal digits can show.
package pinball_disp_pkg;

  // Digit code the 7-segment decoder shows as all segments off.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  // Digit code used to saturate the display on overflow.
  localparam logic [3:0] DIGIT_NINE  = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } enc_state_t;

  // 10**digits - 1, i.e. the largest value shown on 'digits' decimal digits.
  function automatic int max_value(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Shift-add-3 nibble correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
// The result stays inside the nibble; there is no carry out.
module bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD encoder for the score display.
// One conversion takes BIN_W shift cycles plus one finish cycle; the
// finished digits are optionally leading-zero blanked or saturated to
// all nines when the score does not fit on DIGITS digits.
//
//   state | meaning
//   IDLE  | waiting for start; result registers hold the last conversion
//   SHIFT | add-3 correction then one left shift per cycle, BIN_W cycles
//   FIN   | publish digits/overflow, pulse done, drop busy
module score_bcd_encoder
  import pinball_disp_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  input  logic                  i_blank_lz,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(max_value(DIGITS));

  enc_state_t          r_state;
  enc_state_t          w_state_nxt;

  logic [BIN_W-1:0]    r_shreg;
  logic [SCR_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_blank;

  logic                r_busy;
  logic                r_done;
  logic [SCR_W-1:0]    r_bcd;
  logic                r_overflow;

  logic                w_load;
  logic                w_shift;
  logic                w_fin;
  logic                w_last;
  logic [31:0]         w_bin_ext;
  logic                w_bin_gt_max;
  logic [SCR_W-1:0]    w_adj;
  logic [SCR_W-1:0]    w_result;
  logic                w_lead;

  // Overflow is decided on the raw input at the accept edge.
  assign w_bin_ext    = 32'(i_bin);
  assign w_bin_gt_max = (w_bin_ext > MAX_VAL);

  // The shift that brings the counter from 1 to 0 is the last one.
  assign w_last = (r_cnt == CNT_W'(1));

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_nib (r_scratch[4*g +: 4]),
        .o_nib (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Conversion registers: load on accept, corrected shift while in SHIFT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_blank   <= 1'b0;
    end else if (w_load) begin
      r_shreg   <= i_bin;
      r_scratch <= '0;
      r_cnt     <= CNT_W'(BIN_W);
      r_ovf     <= w_bin_gt_max;
      r_blank   <= i_blank_lz;
    end else if (w_shift) begin
      r_scratch <= {w_adj[SCR_W-2:0], r_shreg[BIN_W-1]};
      r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  // Final digit codes: saturate on overflow, else blank leading zeros
  // from the top digit down; the units digit always shows.
  always_comb begin
    w_result = r_scratch;
    w_lead   = 1'b1;
    if (r_ovf) begin
      w_result = {DIGITS{DIGIT_NINE}};
    end else if (r_blank) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (w_lead && (r_scratch[4*i +: 4] == 4'd0)) begin
          w_result[4*i +: 4] = DIGIT_BLANK;
        end else begin
          w_lead = 1'b0;
        end
      end
    end
  end

  // Handshake and published result; results hold until the next FIN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_fin) begin
        r_busy     <= 1'b0;
        r_bcd      <= w_result;
        r_overflow <= r_ovf;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bcd      = r_bcd;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Self-checking bench for score_bcd_encoder (BIN_W=14, DIGITS=4).
module tb_score_bcd_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        blank;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  score_bcd_encoder #(.BIN_W(14), .DIGITS(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_bin      (bin),
    .i_blank_lz (blank),
    .o_busy     (busy),
    .o_done     (done),
    .o_bcd      (bcd),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    bit          bl;
    logic [15:0] exp_bcd;
    bit          exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division; digits above the number's
  // significant-digit count become F when blanking; saturate above 9999.
  function automatic logic [15:0] model_bcd(input int v, input bit bl);
    int nd;
    int t;
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    nd = 1;
    t  = v / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (bl && i >= nd) r[4*i +: 4] = 4'hF;
      else               r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One conversion from IDLE: accept, scramble inputs, time the done pulse.
  task automatic convert(input logic [13:0] b, input bit bl,
                         input logic [15:0] eb, input bit eo, input string tag);
    int n;
    start = 1'b1;
    bin   = b;
    blank = bl;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 14'($urandom);
    blank = 1'($urandom);
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd15);
    chk({tag, " bcd"}, 32'(bcd), 32'(eb));
    chk({tag, " overflow"}, 32'(ovf), 32'(eo));
    chk({tag, " busy at done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done single pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vec_t vecs[12];
    int   n;
    bit   seen;
    logic [13:0] rv;
    bit   rb;

    vecs[0]  = '{14'd1234,  1'b0, 16'h1234, 1'b0};
    vecs[1]  = '{14'd7,     1'b1, 16'hFFF7, 1'b0};
    vecs[2]  = '{14'd0,     1'b1, 16'hFFF0, 1'b0};
    vecs[3]  = '{14'd1005,  1'b1, 16'h1005, 1'b0};
    vecs[4]  = '{14'd12000, 1'b0, 16'h9999, 1'b1};
    vecs[5]  = '{14'd9999,  1'b0, 16'h9999, 1'b0};
    vecs[6]  = '{14'd12000, 1'b1, 16'h9999, 1'b1};
    vecs[7]  = '{14'd0,     1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{14'd10000, 1'b1, 16'h9999, 1'b1};
    vecs[9]  = '{14'd16383, 1'b0, 16'h9999, 1'b1};
    vecs[10] = '{14'd10,    1'b1, 16'hFF10, 1'b0};
    vecs[11] = '{14'd100,   1'b1, 16'hF100, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    blank = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset bcd", 32'(bcd), 32'd0);
    chk("reset overflow", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].bin, vecs[i].bl, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // start held high: accepted in every done cycle, 16-cycle throughput;
    // bin changes while busy must not leak into the result.
    start = 1'b1;
    bin   = 14'd42;
    blank = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
    chk("hold first latency", 32'(n), 32'd16);
    chk("hold first bcd", 32'(bcd), 32'h0042);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (n == 4) bin = 14'd99;
        if (n == 7) bin = 14'd42;
      end while (!done && n < 40);
      chk("hold period", 32'(n), 32'd16);
      chk("hold bcd", 32'(bcd), 32'h0042);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("hold release busy", 32'(busy), 32'd0);

    // Single start pulse with a different value while busy is ignored.
    start = 1'b1;
    bin   = 14'd42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    bin   = 14'd99;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy pulse latency", 32'(n), 32'd15);
    chk("busy pulse bcd", 32'(bcd), 32'h0042);
    @(posedge clk); #1;
    chk("busy pulse no second done", 32'(done), 32'd0);

    // Reset five edges into a conversion aborts it with no done pulse.
    start = 1'b1;
    bin   = 14'd555;
    blank = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort bcd", 32'(bcd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    convert(14'd555, 1'b0, 16'h0555, 1'b0, "after abort");

    // Random sweep against the reference model, plus the range edges.
    convert(14'd9999, 1'b1, model_bcd(9999, 1'b1), 1'b0, "edge 9999");
    convert(14'd10000, 1'b0, model_bcd(10000, 1'b0), 1'b1, "edge 10000");
    for (int k = 0; k < 800; k++) begin
      rv = 14'($urandom_range(0, 16383));
      rb = 1'($urandom_range(0, 1));
      convert(rv, rb, model_bcd(int'(rv), rb), (int'(rv) > 9999), $sformatf("rand bin=%0d bl=%0d", rv, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
